// File: rtl/dependency_check_block.sv
// Decode-stage hazard/forwarding controller: tracks EX/DM/WB destinations,
// picks operand forwarding sources and raises a one-cycle load-use stall.
module dependency_check_block (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] ins,
    output logic [2:0]  mux_sel_A,
    output logic [2:0]  mux_sel_B,
    output logic        imm_sel,
    output logic [7:0]  imm,
    output logic        stall,
    output logic [4:0]  RW_dm,
    output logic        we_dm,
    output logic [4:0]  RW_wb,
    output logic        we_wb
);

    typedef struct packed {
        logic [4:0] rw;
        logic       we;
        logic       is_load;
    } hist_t;

    logic [5:0] opcode;
    logic [4:0] rw;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       is_nop;
    logic       is_store;
    logic       is_load;
    logic       is_imm;
    logic       reads_a;
    logic       reads_b;
    logic       writes;
    logic       load_use;
    hist_t      decoded;
    hist_t      ex_q;
    hist_t      dm_q;
    hist_t      wb_q;

    assign opcode   = ins[23:18];
    assign rw       = ins[17:13];
    assign ra       = ins[12:8];
    assign rb       = ins[7:3];
    assign imm      = ins[7:0];

    assign is_nop   = (opcode == 6'h3F);
    assign is_store = (opcode == 6'h1E);
    assign is_load  = (opcode == 6'h1F);
    assign is_imm   = opcode[5] && !is_nop;
    assign reads_a  = !is_nop;
    assign reads_b  = !is_nop && !is_load && !is_imm;
    assign writes   = !is_nop && !is_store;
    assign imm_sel  = is_imm;
    assign decoded  = {rw, writes, is_load};

    // Youngest producer wins when several stages target the same register.
    function automatic logic [2:0] fwd_sel(input logic [4:0] src, input hist_t e_ex,
                                           input hist_t e_dm, input hist_t e_wb);
        logic [2:0] sel;
        sel = 3'd0;
        if (e_ex.we && e_ex.rw == src)
            sel = 3'd1;
        else if (e_dm.we && e_dm.rw == src)
            sel = 3'd2;
        else if (e_wb.we && e_wb.rw == src)
            sel = 3'd3;
        return sel;
    endfunction

    always_comb begin
        load_use  = ex_q.is_load && ((reads_a && ex_q.rw == ra) || (reads_b && ex_q.rw == rb));
        stall     = !reset && load_use;
        mux_sel_A = 3'd0;
        mux_sel_B = 3'd0;
        if (!reset && !load_use) begin
            if (reads_a)
                mux_sel_A = fwd_sel(ra, ex_q, dm_q, wb_q);
            if (reads_b)
                mux_sel_B = fwd_sel(rb, ex_q, dm_q, wb_q);
        end
    end

    // A stalled instruction stays in decode, so EX receives a bubble instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
            dm_q <= '0;
            wb_q <= '0;
        end else begin
            wb_q <= dm_q;
            dm_q <= ex_q;
            ex_q <= stall ? hist_t'('0) : decoded;
        end
    end

    assign RW_dm = dm_q.rw;
    assign we_dm = dm_q.we;
    assign RW_wb = wb_q.rw;
    assign we_wb = wb_q.we;

endmodule

// File: tb/tb_dependency_check_block.sv
// Scoreboard bench for dependency_check_block: an age-indexed pipeline model
// predicts every cycle's outputs, which are compared at the falling edge.
module tb_dependency_check_block;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] ins = 24'h0;
    logic [2:0]  mux_sel_A;
    logic [2:0]  mux_sel_B;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        stall;
    logic [4:0]  RW_dm;
    logic        we_dm;
    logic [4:0]  RW_wb;
    logic        we_wb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] sel_a;
        logic [2:0] sel_b;
        logic       imm_sel;
        logic [7:0] imm;
        logic       stall;
        logic [4:0] rw_dm;
        logic       we_dm;
        logic [4:0] rw_wb;
        logic       we_wb;
        logic       reg_valid;
    } expect_t;

    expect_t sb_q[$];

    // Model history indexed by age: 0 = EX, 1 = DM, 2 = WB.
    logic [4:0] m_rw[3];
    logic       m_we[3];
    logic       m_ld[3];
    logic       model_valid = 1'b0;

    localparam logic [23:0] NOP = 24'hFC0000;

    dependency_check_block dut (
        .clk(clk), .reset(reset), .ins(ins),
        .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B),
        .imm_sel(imm_sel), .imm(imm), .stall(stall),
        .RW_dm(RW_dm), .we_dm(we_dm), .RW_wb(RW_wb), .we_wb(we_wb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one decode cycle, predicts outputs, checks them, then advances the model.
    task automatic applyStimulus(input logic [23:0] i, input logic rst);
        expect_t e;
        logic [5:0] op;
        logic [4:0] src[2];
        logic       rd[2];
        logic       wr;
        logic       ld;
        logic       st;
        logic [2:0] sel[2];
        expect_t    got;
        @(posedge clk);
        #1;
        ins   = i;
        reset = rst;
        op     = i[23:18];
        src[0] = i[12:8];
        src[1] = i[7:3];
        ld     = (op == 6'h1F);
        rd[0]  = (op != 6'h3F);
        rd[1]  = (op != 6'h3F) && !op[5] && (op != 6'h1F);
        wr     = (op != 6'h3F) && (op != 6'h1E);
        st = 1'b0;
        for (int k = 0; k < 2; k++)
            if (!rst && model_valid && m_ld[0] && rd[k] && m_rw[0] == src[k])
                st = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sel[k] = 3'd0;
            if (!rst && !st && rd[k])
                for (int age = 2; age >= 0; age--)
                    if (m_we[age] && m_rw[age] == src[k])
                        sel[k] = 3'(age + 1);
        end
        e.sel_a     = sel[0];
        e.sel_b     = sel[1];
        e.imm_sel   = op[5] && (op != 6'h3F);
        e.imm       = i[7:0];
        e.stall     = st;
        e.rw_dm     = m_rw[1];
        e.we_dm     = m_we[1];
        e.rw_wb     = m_rw[2];
        e.we_wb     = m_we[2];
        e.reg_valid = model_valid;
        sb_q.push_back(e);

        @(negedge clk);
        got = sb_q.pop_front();
        checkOutput("mux_sel_A", 32'(mux_sel_A), 32'(got.sel_a));
        checkOutput("mux_sel_B", 32'(mux_sel_B), 32'(got.sel_b));
        checkOutput("imm_sel", 32'(imm_sel), 32'(got.imm_sel));
        checkOutput("imm", 32'(imm), 32'(got.imm));
        checkOutput("stall", 32'(stall), 32'(got.stall));
        if (got.reg_valid) begin
            checkOutput("RW_dm", 32'(RW_dm), 32'(got.rw_dm));
            checkOutput("we_dm", 32'(we_dm), 32'(got.we_dm));
            checkOutput("RW_wb", 32'(RW_wb), 32'(got.rw_wb));
            checkOutput("we_wb", 32'(we_wb), 32'(got.we_wb));
        end

        if (rst) begin
            for (int age = 0; age < 3; age++) begin
                m_rw[age] = 5'd0;
                m_we[age] = 1'b0;
                m_ld[age] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            for (int age = 2; age > 0; age--) begin
                m_rw[age] = m_rw[age-1];
                m_we[age] = m_we[age-1];
                m_ld[age] = m_ld[age-1];
            end
            m_rw[0] = st ? 5'd0 : i[17:13];
            m_we[0] = st ? 1'b0 : wr;
            m_ld[0] = st ? 1'b0 : ld;
        end
    endtask

    task automatic flush();
        for (int n = 0; n < 3; n++)
            applyStimulus(NOP, 1'b0);
    endtask

    initial begin
        logic [23:0] pool[8];
        logic [23:0] r;
        for (int age = 0; age < 3; age++) begin
            m_rw[age] = 5'd0;
            m_we[age] = 1'b0;
            m_ld[age] = 1'b0;
        end

        applyStimulus(24'h014C50, 1'b1);
        applyStimulus(24'h014C50, 1'b1);
        checkOutput("reset_sel_a", 32'(mux_sel_A), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_we_dm", 32'(we_dm), 32'd0);
        checkOutput("reset_rw_dm", 32'(RW_dm), 32'd0);

        applyStimulus(24'h014C50, 1'b0);
        applyStimulus(24'h014E50, 1'b0);
        checkOutput("ex_fwd_a", 32'(mux_sel_A), 32'd0);
        checkOutput("ex_fwd_b", 32'(mux_sel_B), 32'd1);
        checkOutput("ex_fwd_imm_sel", 32'(imm_sel), 32'd0);

        flush();
        applyStimulus(24'h014C50, 1'b0);
        applyStimulus(NOP, 1'b0);
        applyStimulus(24'h002A10, 1'b0);
        checkOutput("dm_fwd_a", 32'(mux_sel_A), 32'd2);
        checkOutput("dm_fwd_b", 32'(mux_sel_B), 32'd0);
        checkOutput("dm_rw", 32'(RW_dm), 32'd10);
        checkOutput("dm_we", 32'(we_dm), 32'd1);
        applyStimulus(NOP, 1'b0);
        checkOutput("wb_rw", 32'(RW_wb), 32'd10);
        checkOutput("wb_we", 32'(we_wb), 32'd1);

        flush();
        applyStimulus(24'h014C50, 1'b0);
        applyStimulus(NOP, 1'b0);
        applyStimulus(NOP, 1'b0);
        applyStimulus(24'h002A10, 1'b0);
        checkOutput("wb_fwd_a", 32'(mux_sel_A), 32'd3);
        flush();
        applyStimulus(24'h014C50, 1'b0);
        flush();
        applyStimulus(24'h002A10, 1'b0);
        checkOutput("retired_a", 32'(mux_sel_A), 32'd0);

        flush();
        applyStimulus(24'h7CA100, 1'b0);
        applyStimulus(24'h00C528, 1'b0);
        checkOutput("lu_stall", 32'(stall), 32'd1);
        checkOutput("lu_sel_a", 32'(mux_sel_A), 32'd0);
        checkOutput("lu_sel_b", 32'(mux_sel_B), 32'd0);
        applyStimulus(24'h00C528, 1'b0);
        checkOutput("lu_release_stall", 32'(stall), 32'd0);
        checkOutput("lu_release_a", 32'(mux_sel_A), 32'd2);
        checkOutput("lu_release_b", 32'(mux_sel_B), 32'd2);
        applyStimulus(NOP, 1'b0);
        applyStimulus(NOP, 1'b0);
        applyStimulus(NOP, 1'b0);
        checkOutput("lu_wb_we", 32'(we_wb), 32'd1);
        checkOutput("lu_wb_rw", 32'(RW_wb), 32'd6);

        applyStimulus(24'h8014FF, 1'b0);
        checkOutput("immop_sel", 32'(imm_sel), 32'd1);
        checkOutput("immop_imm", 32'(imm), 32'hFF);
        checkOutput("immop_b", 32'(mux_sel_B), 32'd0);

        flush();
        applyStimulus(24'h7CA100, 1'b0);
        applyStimulus(24'h00C528, 1'b0);
        checkOutput("rst_lu_stall", 32'(stall), 32'd1);
        applyStimulus(24'h00C528, 1'b1);
        applyStimulus(24'h00C528, 1'b0);
        checkOutput("rst_lu_after", 32'(stall), 32'd0);
        checkOutput("rst_lu_we_dm", 32'(we_dm), 32'd0);
        checkOutput("rst_lu_we_wb", 32'(we_wb), 32'd0);

        pool[0] = 24'h014C50; pool[1] = 24'h7CA100; pool[2] = 24'h00C528;
        pool[3] = 24'h8014FF; pool[4] = NOP;        pool[5] = 24'h002A10;
        pool[6] = 24'h78A528; pool[7] = 24'h7C2500;
        for (int n = 0; n < 400; n++) begin
            r = pool[$urandom_range(7)];
            if ($urandom_range(3) == 0) begin
                r[17:13] = 5'($urandom_range(3));
                r[12:8]  = 5'($urandom_range(3));
                r[7:3]   = 5'($urandom_range(3));
            end
            applyStimulus(r, ($urandom_range(40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
